// File: rtl/div_ctrl_if.sv
// Bundle of the issue-side request/response handshake and the divider-side
// start/result signals of div_ctrl. The slave modport is the controller's view.
// The master modport is the surrounding pipeline/divider view.
interface div_ctrl_if #(
   parameter int unsigned XLEN = 64
);
   // Issue port
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_op;
   logic            req_word;
   logic [XLEN-1:0] req_src1;
   logic [XLEN-1:0] req_src2;
   // Result port
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;
   logic            flush;
   // Shared iterative divider
   logic            d_valid;
   logic            d_ready;
   logic            d_word;
   logic            d_signed;
   logic [XLEN-1:0] d_dividend;
   logic [XLEN-1:0] d_divisor;
   logic            d_flush;
   logic            d_out_valid;
   logic [XLEN-1:0] d_quotient;
   logic [XLEN-1:0] d_remainder;

   modport slave (
      input  req_valid, req_op, req_word, req_src1, req_src2,
      input  resp_ready, flush,
      input  d_ready, d_out_valid, d_quotient, d_remainder,
      output req_ready, resp_valid, resp_data,
      output d_valid, d_word, d_signed, d_dividend, d_divisor, d_flush
   );

   modport master (
      output req_valid, req_op, req_word, req_src1, req_src2,
      output resp_ready, flush,
      output d_ready, d_out_valid, d_quotient, d_remainder,
      input  req_ready, resp_valid, resp_data,
      input  d_valid, d_word, d_signed, d_dividend, d_divisor, d_flush
   );
endinterface

// File: rtl/div_ctrl.sv
// Sequencing front-end between the M-extension issue port and the shared
// iterative divider. Divide-by-zero and signed overflow are resolved locally;
// all other requests are sent to the divider and the selected, width-adjusted
// result is held until the consumer takes it.
// Optional feature: define DIV_CTRL_CACHE_EN to keep the last divider result
// so a request with identical operands (e.g. REM after DIV) skips the divider.
module div_ctrl #(
   parameter int unsigned XLEN = 64
) (
   input logic      clk,
   input logic      rst,
   div_ctrl_if.slave bus
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [1:0]      op_q;
   logic            word_q;
   logic            signed_q;
   logic [XLEN-1:0] src1_q;
   logic [XLEN-1:0] src2_q;
   logic [XLEN-1:0] resp_data_q, resp_data_d;

   logic            accept;
   logic            capture;
   logic            req_signed;
   logic [XLEN-1:0] req_dividend;
   logic            div_zero;
   logic            signed_ovf;
   logic [XLEN-1:0] special_sel;
   logic [XLEN-1:0] div_sel;
   logic            cache_hit;
   logic [XLEN-1:0] cache_sel;

   // Word results are always the sign-extension of bits [31:0]
   function automatic logic [XLEN-1:0] fit(input logic word, input logic [XLEN-1:0] v);
      return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   assign accept     = bus.req_valid && bus.req_ready;
   assign capture    = (state_q == StWait) && bus.d_out_valid && !bus.flush;
   assign req_signed = !bus.req_op[0];

   // Local resolution of the cases the divider is never asked to handle
   assign req_dividend = fit(bus.req_word, bus.req_src1);
   assign div_zero     = bus.req_word ? (bus.req_src2[31:0] == 32'h0) : (bus.req_src2 == '0);
   assign signed_ovf   = req_signed &&
                         (bus.req_word ? ((bus.req_src1[31:0] == 32'h8000_0000) &&
                                          (bus.req_src2[31:0] == 32'hFFFF_FFFF))
                                       : ((bus.req_src1 == MinNeg) && (bus.req_src2 == '1)));
   // Zero divisor: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
   assign special_sel  = bus.req_op[1] ? (div_zero ? req_dividend : '0)
                                       : (div_zero ? '1 : req_dividend);

   assign div_sel = fit(word_q, op_q[1] ? bus.d_remainder : bus.d_quotient);

`ifdef DIV_CTRL_CACHE_EN
   logic [XLEN-1:0] last_src1_q, last_src2_q, last_q_q, last_r_q;
   logic            last_word_q, last_signed_q, cache_vld_q;

   // Remember the most recent completed divider result; only rst invalidates it
   always_ff @(posedge clk) begin
      if (rst) begin
         last_src1_q   <= '0;
         last_src2_q   <= '0;
         last_q_q      <= '0;
         last_r_q      <= '0;
         last_word_q   <= 1'b0;
         last_signed_q <= 1'b0;
         cache_vld_q   <= 1'b0;
      end else if (capture) begin
         last_src1_q   <= src1_q;
         last_src2_q   <= src2_q;
         last_q_q      <= bus.d_quotient;
         last_r_q      <= bus.d_remainder;
         last_word_q   <= word_q;
         last_signed_q <= signed_q;
         cache_vld_q   <= 1'b1;
      end
   end

   assign cache_hit = cache_vld_q && (bus.req_src1 == last_src1_q) &&
                      (bus.req_src2 == last_src2_q) && (bus.req_word == last_word_q) &&
                      (req_signed == last_signed_q);
   assign cache_sel = fit(bus.req_word, bus.req_op[1] ? last_r_q : last_q_q);
`else
   assign cache_hit = 1'b0;
   assign cache_sel = '0;
`endif

   // Next-state and result selection; flush overrides every transition
   always_comb begin
      state_d     = state_q;
      resp_data_d = resp_data_q;
      if (bus.flush) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  if (div_zero || signed_ovf) begin
                     resp_data_d = special_sel;
                     state_d     = StResp;
                  end else if (cache_hit) begin
                     resp_data_d = cache_sel;
                     state_d     = StResp;
                  end else begin
                     state_d = StIssue;
                  end
               end
            end
            StIssue: begin
               if (bus.d_valid) state_d = StWait;
            end
            StWait: begin
               if (capture) begin
                  resp_data_d = div_sel;
                  state_d     = StResp;
               end
            end
            StResp: begin
               if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and held result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         resp_data_q <= resp_data_d;
      end
   end

   // Operand latch on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= 2'b00;
         word_q   <= 1'b0;
         signed_q <= 1'b0;
         src1_q   <= '0;
         src2_q   <= '0;
      end else if (accept) begin
         op_q     <= bus.req_op;
         word_q   <= bus.req_word;
         signed_q <= req_signed;
         src1_q   <= bus.req_src1;
         src2_q   <= bus.req_src2;
      end
   end

   assign bus.req_ready  = (state_q == StIdle) && !bus.flush;
   assign bus.resp_valid = (state_q == StResp) && !bus.flush;
   assign bus.resp_data  = resp_data_q;
   // Start is withheld on flush/rst so the divider never begins orphaned work
   assign bus.d_valid    = (state_q == StIssue) && bus.d_ready && !bus.flush && !rst;
   assign bus.d_word     = word_q;
   assign bus.d_signed   = signed_q;
   assign bus.d_dividend = src1_q;
   assign bus.d_divisor  = src2_q;
   assign bus.d_flush    = bus.flush && (state_q == StWait);

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed scenarios plus randomized operations checked
// against an arithmetic reference; includes a small iterative-divider model.
module tb_div_ctrl;
   localparam int unsigned XLEN = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_ctrl_if #(.XLEN(XLEN)) bus ();
   div_ctrl #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference-model state: last operands that completed through the divider
   bit          m_vld = 0;
   logic [63:0] m_a, m_b;
   bit          m_w, m_s;

   // Divider model state
   int          div_lat = 3;
   int          busy_cnt;
   logic        busy;
   int          dv_cnt = 0;
   logic [63:0] mq, mr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // RISC-V division rules; word results get random upper bits (divider junk)
   function automatic logic [127:0] div_raw(input logic sgn, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
      logic [63:0] q, r;
      logic [31:0] q32, r32;
      int sa, sb;
      longint la, lb;
      if (w) begin
         if (b[31:0] == 32'h0) begin
            q32 = '1; r32 = a[31:0];
         end else if (sgn) begin
            sa = a[31:0]; sb = b[31:0];
            if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
               q32 = a[31:0]; r32 = 32'h0;
            end else begin
               q32 = sa / sb; r32 = sa % sb;
            end
         end else begin
            q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
         end
         q = {$urandom, q32};
         r = {$urandom, r32};
      end else begin
         if (b == 64'h0) begin
            q = '1; r = a;
         end else if (sgn) begin
            la = a; lb = b;
            if (a == 64'h8000_0000_0000_0000 && b == '1) begin
               q = a; r = 64'h0;
            end else begin
               q = la / lb; r = la % lb;
            end
         end else begin
            q = a / b; r = a % b;
         end
      end
      return {q, r};
   endfunction

   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
      logic [127:0] qr;
      logic [63:0] sel;
      qr  = div_raw(!op[0], w, a, b);
      sel = op[1] ? qr[63:0] : qr[127:64];
      return w ? {{32{sel[31]}}, sel[31:0]} : sel;
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
      if (w) return (b[31:0] == 32'h0) ||
                    (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      return (b == 64'h0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
   endfunction

   // Iterative divider model: accepts on d_valid, pulses d_out_valid div_lat cycles later
   assign bus.d_ready = !busy;
   always @(posedge clk) begin
      bus.d_out_valid <= 1'b0;
      if (rst) begin
         busy     <= 1'b0;
         busy_cnt <= 0;
      end else if (bus.d_flush) begin
         busy <= 1'b0;
      end else if (busy) begin
         if (busy_cnt <= 1) begin
            busy            <= 1'b0;
            bus.d_out_valid <= 1'b1;
            bus.d_quotient  <= mq;
            bus.d_remainder <= mr;
         end else begin
            busy_cnt <= busy_cnt - 1;
         end
      end else if (bus.d_valid && bus.d_ready) begin
         busy     <= 1'b1;
         busy_cnt <= div_lat;
         {mq, mr} <= div_raw(bus.d_signed, bus.d_word, bus.d_dividend, bus.d_divisor);
         dv_cnt   <= dv_cnt + 1;
      end
   end

   // One complete transaction; hold = cycles resp_ready stays low after resp_valid
   task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input int hold,
                         output logic [63:0] got);
      logic [63:0] exp;
      bit fast, hit, seen, prev_dov;
      int dv0, lat;
      exp = ref_result(op, w, a, b);
      hit = 0;
`ifdef DIV_CTRL_CACHE_EN
      hit = m_vld && a == m_a && b == m_b && w == m_w && (!op[0]) == m_s;
`endif
      fast = is_special(op, w, a, b) || hit;
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_word = w;
      bus.req_src1 = a; bus.req_src2 = b;
      @(negedge clk);
      check({tag, ".req_ready"}, bus.req_ready, 64'd1);
      dv0 = dv_cnt;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 0; seen = 0; prev_dov = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (bus.resp_valid) seen = 1;
         else prev_dov = bus.d_out_valid;
      end
      check({tag, ".resp_seen"}, seen, 64'd1);
      got = bus.resp_data;
      if (seen) begin
         if (fast) begin
            check({tag, ".fast_latency"}, lat, 64'd1);
            check({tag, ".no_d_valid"}, dv_cnt - dv0, 64'd0);
         end else begin
            check({tag, ".after_d_out_valid"}, prev_dov, 64'd1);
            check({tag, ".one_d_valid"}, dv_cnt - dv0, 64'd1);
         end
         check({tag, ".data"}, bus.resp_data, exp);
         check({tag, ".req_ready_in_resp"}, bus.req_ready, 64'd0);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, bus.resp_valid, 64'd1);
            check({tag, ".hold_data"}, bus.resp_data, exp);
            check({tag, ".hold_req_ready"}, bus.req_ready, 64'd0);
         end
         bus.resp_ready = 1'b1;
         @(posedge clk); #1;
         bus.resp_ready = 1'b0;
         @(negedge clk);
         check({tag, ".post_resp_valid"}, bus.resp_valid, 64'd0);
         check({tag, ".post_req_ready"}, bus.req_ready, 64'd1);
      end
      if (!fast) begin
         m_vld = 1; m_a = a; m_b = b; m_w = w; m_s = !op[0];
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] got, a, b;
      logic [1:0]  op;
      logic        w;
      int          rv, dv0;

      rst = 1'b1;
      bus.req_valid = 0; bus.req_op = 0; bus.req_word = 0;
      bus.req_src1 = 0; bus.req_src2 = 0; bus.resp_ready = 0; bus.flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.req_ready", bus.req_ready, 64'd1);
      check("reset.resp_valid", bus.resp_valid, 64'd0);
      check("reset.resp_data", bus.resp_data, 64'd0);
      check("reset.d_valid", bus.d_valid, 64'd0);
      check("reset.d_flush", bus.d_flush, 64'd0);
      #1 rst = 1'b0;

      // Signed divider path
      run_op("div_neg", 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0, got);
      check("div_neg.value", got, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op("rem_neg", 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0, got);
      check("rem_neg.value", got, 64'hFFFF_FFFF_FFFF_FFFE);

      // Divide by zero
      run_op("divu_zero", 2'd1, 1'b0, 64'h1234, 64'd0, 0, got);
      check("divu_zero.value", got, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("remu_zero", 2'd3, 1'b0, 64'h1234, 64'd0, 0, got);
      check("remu_zero.value", got, 64'h1234);

      // Word signed overflow
      run_op("divw_ovf", 2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 0, got);
      check("divw_ovf.value", got, 64'hFFFF_FFFF_8000_0000);
      run_op("remw_ovf", 2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 0, got);
      check("remw_ovf.value", got, 64'h0);

      // Backpressure, then the cache-eligible REM
      run_op("div_hold", 2'd0, 1'b0, 64'd100, 64'd7, 5, got);
      check("div_hold.value", got, 64'd14);
      run_op("rem_after", 2'd2, 1'b0, 64'd100, 64'd7, 0, got);
      check("rem_after.value", got, 64'd2);

      // Flush 10 cycles into WAIT
      div_lat = 30;
      @(posedge clk); #1;
      bus.req_valid = 1; bus.req_op = 2'd0; bus.req_word = 0;
      bus.req_src1 = 64'd1000; bus.req_src2 = 64'd3;
      @(posedge clk); #1;
      bus.req_valid = 0;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(negedge clk);
      check("flush.d_flush", bus.d_flush, 64'd1);
      check("flush.resp_valid", bus.resp_valid, 64'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush.req_ready_next", bus.req_ready, 64'd1);
      rv = 0;
      repeat (35) begin
         @(negedge clk);
         if (bus.resp_valid) rv++;
      end
      check("flush.no_resp", rv, 64'd0);
      div_lat = 3;
      run_op("divu_after_flush", 2'd1, 1'b0, 64'd9, 64'd2, 0, got);
      check("divu_after_flush.value", got, 64'd4);

      // rst in the cycle after accept: no start pulse, back to IDLE
      dv0 = dv_cnt;
      @(posedge clk); #1;
      bus.req_valid = 1; bus.req_op = 2'd1; bus.req_word = 0;
      bus.req_src1 = 64'd55; bus.req_src2 = 64'd5;
      @(posedge clk); #1;
      bus.req_valid = 0;
      rst = 1'b1;
      @(negedge clk);
      check("rst.d_valid", bus.d_valid, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_vld = 0;
      @(negedge clk);
      check("rst.req_ready", bus.req_ready, 64'd1);
      check("rst.resp_valid", bus.resp_valid, 64'd0);
      check("rst.resp_data", bus.resp_data, 64'd0);
      check("rst.no_start", dv_cnt - dv0, 64'd0);

      // Randomized operations
      a = 64'd1; b = 64'd1;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
               0: a = 64'h8000_0000_0000_0000;
               1: a = 64'h0000_0000_8000_0000;
               default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 7))
               0: b = 64'h0;
               1: b = '1;
               2: b = 64'h0000_0000_FFFF_FFFF;
               3: b = 64'($urandom_range(1, 20));
               default: b = {$urandom, $urandom};
            endcase
         end
         div_lat = $urandom_range(1, 6);
         run_op($sformatf("rand%0d", i), op, w, a, b, $urandom_range(0, 2), got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
